// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty sequencer.
//   state_t          : sequencer FSM states
//   CW_W_DEF         : default duty control word width
//   PWM_PERIOD_CLKS  : clocks per PWM period at the default width
package pwm_pkg;

  localparam int unsigned CW_W_DEF        = 8;
  localparam int unsigned PWM_PERIOD_CLKS = 2 ** CW_W_DEF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RAMP  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

endpackage

// File: rtl/pwm_step_calc.sv
// Combinational step toward a target duty value without overshoot.
//   cw        : current duty word
//   target    : final duty word
//   step      : step magnitude
//   next_cw   : cw moved one step toward target, clamped at target
//   at_target : cw already equals target
module pwm_step_calc #(
  parameter int unsigned CW_W = 8
) (
  input  logic [CW_W-1:0] cw,
  input  logic [CW_W-1:0] target,
  input  logic [CW_W-1:0] step,
  output logic [CW_W-1:0] next_cw,
  output logic            at_target
);

  localparam int unsigned EW = CW_W + 1;

  logic [EW-1:0] cw_e;
  logic [EW-1:0] tgt_e;
  logic [EW-1:0] step_e;
  logic [EW-1:0] dist_e;
  logic          going_up;

  // Distances are taken in one extra bit so nothing wraps.
  always_comb begin
    cw_e      = EW'(cw);
    tgt_e     = EW'(target);
    step_e    = EW'(step);
    going_up  = (tgt_e > cw_e);
    at_target = (cw == target);
    dist_e    = going_up ? (tgt_e - cw_e) : (cw_e - tgt_e);
    if (dist_e <= step_e) begin
      next_cw = target;
    end else if (going_up) begin
      next_cw = CW_W'(cw_e + step_e);
    end else begin
      next_cw = CW_W'(cw_e - step_e);
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Ramps the PWM duty word from a start value to a target in fixed steps,
// holding each value for cfg_hold+1 PWM periods and only updating on
// PWM period boundaries.
//   clk, rst_n     : clock, async active-low reset
//   start, abort   : one-cycle command pulses
//   cfg_*          : ramp configuration, latched on an accepted start
//   period_end     : one-cycle pulse at PWM counter wrap
//   pwm_cw         : duty word to the PWM controller
//   busy/done/err  : status (busy level, done and err one-cycle pulses)
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned CW_W   = CW_W_DEF,
  parameter int unsigned HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CW_W-1:0]   cfg_start_cw,
  input  logic [CW_W-1:0]   cfg_target_cw,
  input  logic [CW_W-1:0]   cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic              period_end,
  output logic [CW_W-1:0]   pwm_cw,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state_q, state_d;
  logic [CW_W-1:0]   cw_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CW_W-1:0]   start_cw_q, start_cw_d;
  logic [CW_W-1:0]   target_q, target_d;
  logic [CW_W-1:0]   step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              busy_d, done_d, err_d;

  logic [CW_W-1:0]   next_cw;
  logic              at_target;
  logic              start_req;
  logic              bad_cfg;

  pwm_step_calc #(.CW_W(CW_W)) u_step_calc (
    .cw        (pwm_cw),
    .target    (target_q),
    .step      (step_q),
    .next_cw   (next_cw),
    .at_target (at_target)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pwm_cw     <= '0;
      hold_cnt_q <= '0;
      start_cw_q <= '0;
      target_q   <= '0;
      step_q     <= '0;
      hold_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwm_cw     <= cw_d;
      hold_cnt_q <= hold_cnt_d;
      start_cw_q <= start_cw_d;
      target_q   <= target_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d    = state_q;
    cw_d       = pwm_cw;
    hold_cnt_d = hold_cnt_q;
    start_cw_d = start_cw_q;
    target_d   = target_q;
    step_d     = step_q;
    hold_d     = hold_q;
    err_d      = 1'b0;

    // abort beats a simultaneous start
    start_req = start && !abort;
    bad_cfg   = (cfg_step == '0) && (cfg_start_cw != cfg_target_cw);

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          if (bad_cfg) begin
            err_d = 1'b1;
          end else begin
            start_cw_d = cfg_start_cw;
            target_d   = cfg_target_cw;
            step_d     = cfg_step;
            hold_d     = cfg_hold;
            state_d    = S_ARM;
          end
        end
      end
      S_ARM: begin
        if (period_end) begin
          cw_d       = start_cw_q;
          hold_cnt_d = hold_q;
          state_d    = S_RAMP;
        end
      end
      S_RAMP: begin
        if (period_end) begin
          if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          end else if (at_target) begin
            state_d = S_DONE;
          end else begin
            cw_d       = next_cw;
            hold_cnt_d = hold_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ABORT: begin
        if (period_end) begin
          cw_d    = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Datapath effects of the current state still apply; only the state is overridden.
    if (abort && (state_q != S_IDLE) && (state_q != S_ABORT)) begin
      state_d = S_ABORT;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

endmodule
